// File: rtl/aemb_pkg.sv
// rtl/aemb_pkg.sv - shared fetch-control codes, vectors, state enum and event priority helper
package aemb_pkg;

    typedef enum logic [1:0] {
        FSM_RUN   = 2'b00,
        FSM_HWINT = 2'b01,
        FSM_HWEXC = 2'b10,
        FSM_SWEXC = 2'b11
    } fsm_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VECT  = 2'd2
    } state_t;

    localparam logic [31:0] VEC_SWEXC = 32'h0000_0008;
    localparam logic [31:0] VEC_HWINT = 32'h0000_0010;
    localparam logic [31:0] VEC_HWEXC = 32'h0000_0020;

    function automatic fsm_code_t pick_event(input logic hw, input logic sw, input logic irq);
        fsm_code_t code;
        code = FSM_RUN;
        if (hw)       code = FSM_HWEXC;
        else if (sw)  code = FSM_SWEXC;
        else if (irq) code = FSM_HWINT;
        return code;
    endfunction

endpackage

// File: rtl/aemb_fetch_ctrl_if.sv
// rtl/aemb_fetch_ctrl_if.sv - instruction bus and pipeline control bundle for the fetch sequencer
interface aemb_fetch_ctrl_if #(
    parameter int ISIZ = 32
);
    logic            iwb_stb_o;
    logic            iwb_ack_i;
    logic            dwb_stall;
    logic            sys_int_i;
    logic            rMSR_IE;
    logic            rHWEXC;
    logic            rSWEXC;
    logic            rBRA;
    logic [ISIZ-1:0] rPC;
    logic            nrun;
    logic [1:0]      rFSM;
    logic [ISIZ-1:0] rEPC;
    logic            rINTACK;
    logic            rWDTERR;

    modport master (
        output iwb_stb_o, nrun, rFSM, rEPC, rINTACK, rWDTERR,
        input  iwb_ack_i, dwb_stall, sys_int_i, rMSR_IE, rHWEXC, rSWEXC, rBRA, rPC
    );

    modport slave (
        input  iwb_stb_o, nrun, rFSM, rEPC, rINTACK, rWDTERR,
        output iwb_ack_i, dwb_stall, sys_int_i, rMSR_IE, rHWEXC, rSWEXC, rBRA, rPC
    );
endinterface

// File: rtl/aemb_sync.sv
// rtl/aemb_sync.sv - multi-stage falling-edge synchroniser for the external interrupt level
module aemb_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/aemb_fetch_ctrl.sv
// rtl/aemb_fetch_ctrl.sv - fetch sequencer: strobe, nrun, event arbitration, EPC capture, ack watchdog
module aemb_fetch_ctrl #(
    parameter int          ISIZ     = 32,
    parameter int          IRQ_SYNC = 2,
    parameter int unsigned WDT_MAX  = 255
) (
    input  logic                 nclk,
    input  logic                 rst,
    aemb_fetch_ctrl_if.master    bus
);
    import aemb_pkg::*;

    localparam int WDT_W = (WDT_MAX > 255) ? $clog2(WDT_MAX + 1) : 8;
    localparam logic [WDT_W-1:0] WDT_LIM = WDT_W'(WDT_MAX);

    state_t          state_q, state_d;
    fsm_code_t       fsm_q, fsm_d;
    fsm_code_t       win;
    logic [ISIZ-1:0] epc_q, epc_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic intack_q, intack_d;
    logic wdterr_q, wdterr_d;
    logic p_hwexc_q, p_hwexc_d;
    logic p_swexc_q, p_swexc_d;
    logic in_svc_q, in_svc_d;
    logic ie_q, ie_d;
    logic irq_sync, active, nrun, take, wdt_fire;

    aemb_sync #(.STAGES(IRQ_SYNC)) u_irq_sync (
        .clk (nclk),
        .rst (rst),
        .d   (bus.sys_int_i),
        .q   (irq_sync)
    );

    always_comb begin
        active   = (state_q != ST_IDLE);
        nrun     = active & bus.iwb_ack_i & ~bus.dwb_stall;
        // A pulse arriving on the take edge competes immediately, so HWEXC beats a same-cycle HWINT
        win      = pick_event(p_hwexc_q | bus.rHWEXC, p_swexc_q | bus.rSWEXC,
                              irq_sync & bus.rMSR_IE & ~in_svc_q);
        take     = (state_q == ST_FETCH) & nrun & ~bus.rBRA & (win != FSM_RUN);

        wdt_fire = 1'b0;
        wdt_d    = wdt_q;
        if (WDT_MAX != 0) begin
            if (active & ~bus.iwb_ack_i) begin
                if (wdt_q + WDT_W'(1) == WDT_LIM) begin
                    wdt_fire = 1'b1;
                    wdt_d    = '0;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
            end else if (bus.iwb_ack_i) begin
                wdt_d = '0;
            end
        end

        p_hwexc_d = p_hwexc_q | bus.rHWEXC | wdt_fire;
        p_swexc_d = p_swexc_q | bus.rSWEXC;
        wdterr_d  = wdterr_q | wdt_fire;
        ie_d      = bus.rMSR_IE;
        in_svc_d  = in_svc_q & ~(bus.rMSR_IE & ~ie_q);
        intack_d  = 1'b0;
        fsm_d     = fsm_q;
        epc_d     = epc_q;
        state_d   = state_q;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (take) begin
                    fsm_d   = win;
                    epc_d   = bus.rPC;
                    state_d = ST_VECT;
                    case (win)
                        FSM_HWEXC: p_hwexc_d = 1'b0;
                        FSM_SWEXC: p_swexc_d = 1'b0;
                        FSM_HWINT: begin
                            intack_d = 1'b1;
                            in_svc_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_VECT: begin
                if (nrun) begin
                    fsm_d   = FSM_RUN;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge nclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fsm_q     <= FSM_RUN;
            epc_q     <= '0;
            wdt_q     <= '0;
            intack_q  <= 1'b0;
            wdterr_q  <= 1'b0;
            p_hwexc_q <= 1'b0;
            p_swexc_q <= 1'b0;
            in_svc_q  <= 1'b0;
            ie_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            fsm_q     <= fsm_d;
            epc_q     <= epc_d;
            wdt_q     <= wdt_d;
            intack_q  <= intack_d;
            wdterr_q  <= wdterr_d;
            p_hwexc_q <= p_hwexc_d;
            p_swexc_q <= p_swexc_d;
            in_svc_q  <= in_svc_d;
            ie_q      <= ie_d;
        end
    end

    assign bus.iwb_stb_o = active;
    assign bus.nrun      = nrun;
    assign bus.rFSM      = fsm_q;
    assign bus.rEPC      = epc_q;
    assign bus.rINTACK   = intack_q;
    assign bus.rWDTERR   = wdterr_q;
endmodule
